mm2s_read_check: RTL and testbench

//  Read-side counterpart of the S2MM stream writer: issues one AXI DataMover MM2S command per start pulse,

---
 rtl/axi_dm_pkg.sv | 41 ++++
 rtl/mm2s_pattern_check.sv | 58 +++++
 rtl/mm2s_read_check.sv | 189 ++++++++++++++++++
 tb/tb_mm2s_read_check.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_dm_pkg.sv
// Shared AXI DataMover definitions: MM2S command/status layouts, FSM states
// and a helper that classifies a returned status word.
package axi_dm_pkg;

    localparam int DM_CMD_W = 72;
    localparam int DM_STS_W = 8;

    // MM2S command word, most-significant field first
    typedef struct packed {
        logic [3:0]  rsvd;
        logic [3:0]  tag;
        logic [31:0] saddr;
        logic        drr;
        logic        eof;
        logic [5:0]  dsa;
        logic        cmd_type;
        logic [22:0] btt;
    } dm_cmd_t;

    // MM2S status word returned once per command
    typedef struct packed {
        logic       okay;
        logic       slverr;
        logic       decerr;
        logic       interr;
        logic [3:0] tag;
    } dm_sts_t;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        RUN
    } mm2s_state_t;

    // A status word is bad when OKAY is missing, any error bit is set,
    // or it answers a command other than the one we issued.
    function automatic logic dmStsBad(input dm_sts_t sts, input logic [3:0] expTag);
        return !sts.okay || sts.slverr || sts.decerr || sts.interr || (sts.tag != expTag);
    endfunction

endpackage

// File: rtl/mm2s_pattern_check.sv
// Expected-word generator and comparator for read-back data. The expected
// word starts at SEED and decrements once per accepted beat; only bytes with
// their keep bit set are compared. Counts mismatching beats (saturating).
module mm2s_pattern_check
    import axi_dm_pkg::*;
#(
    parameter int                DATA_W = 32,
    parameter logic [DATA_W-1:0] SEED   = 32'hFFFF_FFFF,
    parameter int                BEAT_W = 21
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_clear,
    input  logic                i_beat,
    input  logic [DATA_W-1:0]   i_data,
    input  logic [DATA_W/8-1:0] i_keep,
    output logic                o_mismatch,
    output logic [BEAT_W-1:0]   o_errBeats
);

    localparam int BPB = DATA_W / 8;

    logic [DATA_W-1:0] r_expWord;
    logic [BEAT_W-1:0] r_errBeats;
    logic              w_diff;

    // Byte-wise compare of the incoming beat against the expected word
    always_comb begin
        w_diff = 1'b0;
        for (int b = 0; b < BPB; b++) begin
            if (i_keep[b] && (i_data[8*b +: 8] != r_expWord[8*b +: 8])) begin
                w_diff = 1'b1;
            end
        end
    end

    assign o_mismatch = i_beat && w_diff;
    assign o_errBeats = r_errBeats;

    // Expected word restarts at SEED per transfer and steps down each beat
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_expWord <= SEED;
        end else if (i_beat) begin
            r_expWord <= r_expWord - DATA_W'(1);
        end
    end

    // Saturating count of beats that failed the compare
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_errBeats <= '0;
        end else if (o_mismatch && (r_errBeats != '1)) begin
            r_errBeats <= r_errBeats + BEAT_W'(1);
        end
    end

endmodule

// File: rtl/mm2s_read_check.sv
// MM2S read-back checker: issues one DataMover MM2S command per start pulse,
// sinks the returned stream, counts beats, checks length and status word.
// Optional data-pattern checking is built when MM2S_READ_CHECK_DATA_CHECK_EN
// is defined; otherwise err_beats reads zero and data content is ignored.
module mm2s_read_check
    import axi_dm_pkg::*;
#(
    parameter int                DATA_W = 32,
    parameter logic [DATA_W-1:0] SEED   = 32'hFFFF_FFFF,
    parameter int                BEAT_W = 21
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [31:0]         base_addr,
    input  logic [22:0]         btt,
    input  logic [3:0]          tag,
    output logic [DM_CMD_W-1:0] cmd_tdata,
    output logic                cmd_tvalid,
    input  logic                cmd_tready,
    input  logic [DATA_W-1:0]   s_tdata,
    input  logic [DATA_W/8-1:0] s_tkeep,
    input  logic                s_tlast,
    input  logic                s_tvalid,
    output logic                s_tready,
    input  logic [DM_STS_W-1:0] sts_tdata,
    input  logic                sts_tvalid,
    output logic                sts_tready,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [BEAT_W-1:0]   beat_cnt,
    output logic [BEAT_W-1:0]   err_beats
);

    localparam int BPB    = DATA_W / 8;
    localparam int BPB_SH = $clog2(BPB);

    mm2s_state_t       r_state;
    mm2s_state_t       w_stateNext;
    logic [3:0]        r_tag;
    logic [31:0]       r_addr;
    logic [22:0]       r_btt;
    logic [23:0]       r_expBeats;
    logic [BEAT_W-1:0] r_beatCnt;
    logic              r_dataDone;
    logic              r_stsDone;
    logic              r_err;
    logic              r_done;

    dm_cmd_t           w_cmd;
    dm_sts_t           w_sts;
    logic              w_startOk;
    logic              w_startZero;
    logic              w_cmdFire;
    logic              w_beat;
    logic              w_lastBeat;
    logic              w_stsFire;
    logic              w_finish;
    logic              w_lenErr;
    logic              w_stsErr;
    logic              w_mismatch;
    logic [23:0]       w_cntPlus;
    logic [BEAT_W-1:0] w_errBeats;

    assign w_startOk   = (r_state == IDLE) && start && (btt != '0);
    assign w_startZero = (r_state == IDLE) && start && (btt == '0);
    assign w_cmdFire   = (r_state == CMD) && cmd_tready;

    assign cmd_tvalid  = (r_state == CMD);
    assign s_tready    = (r_state == RUN) && !r_dataDone;
    assign sts_tready  = (r_state == RUN) && !r_stsDone;

    assign w_beat      = s_tvalid && s_tready;
    assign w_lastBeat  = w_beat && s_tlast;
    assign w_stsFire   = sts_tvalid && sts_tready;
    assign w_finish    = (r_state == RUN) && (r_dataDone || w_lastBeat) && (r_stsDone || w_stsFire);

    assign w_cntPlus   = 24'(r_beatCnt) + 24'd1;
    assign w_lenErr    = w_lastBeat && (w_cntPlus != r_expBeats);
    assign w_sts       = dm_sts_t'(sts_tdata);
    assign w_stsErr    = w_stsFire && dmStsBad(w_sts, r_tag);

    assign w_cmd.rsvd     = 4'h0;
    assign w_cmd.tag      = r_tag;
    assign w_cmd.saddr    = r_addr;
    assign w_cmd.drr      = 1'b0;
    assign w_cmd.eof      = 1'b1;
    assign w_cmd.dsa      = 6'h00;
    assign w_cmd.cmd_type = 1'b1;
    assign w_cmd.btt      = r_btt;
    assign cmd_tdata      = w_cmd;

    assign busy      = (r_state != IDLE);
    assign done      = r_done;
    assign err       = r_err;
    assign beat_cnt  = r_beatCnt;
    assign err_beats = w_errBeats;

`ifdef MM2S_READ_CHECK_DATA_CHECK_EN
    mm2s_pattern_check #(
        .DATA_W (DATA_W),
        .SEED   (SEED),
        .BEAT_W (BEAT_W)
    ) u_patternCheck (
        .clk        (clk),
        .reset      (reset),
        .i_clear    (w_startOk || w_startZero),
        .i_beat     (w_beat),
        .i_data     (s_tdata),
        .i_keep     (s_tkeep),
        .o_mismatch (w_mismatch),
        .o_errBeats (w_errBeats)
    );
`else
    logic w_unusedData;
    assign w_unusedData = ^{s_tdata, s_tkeep};
    assign w_mismatch   = 1'b0;
    assign w_errBeats   = '0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next state: launch, wait for command acceptance, run until data and status are both in
    always_comb begin
        w_stateNext = r_state;
        unique case (r_state)
            IDLE:    if (w_startOk) w_stateNext = CMD;
            CMD:     if (w_cmdFire) w_stateNext = RUN;
            RUN:     if (w_finish)  w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    // Transfer bookkeeping: latch command, count beats, collect errors, pulse done
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tag      <= '0;
            r_addr     <= '0;
            r_btt      <= '0;
            r_expBeats <= '0;
            r_beatCnt  <= '0;
            r_dataDone <= 1'b0;
            r_stsDone  <= 1'b0;
            r_err      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_startOk) begin
                r_tag      <= tag;
                r_addr     <= base_addr;
                r_btt      <= btt;
                r_expBeats <= (24'(btt) + 24'(BPB - 1)) >> BPB_SH;
                r_beatCnt  <= '0;
                r_dataDone <= 1'b0;
                r_stsDone  <= 1'b0;
                r_err      <= 1'b0;
            end else if (w_startZero) begin
                r_beatCnt <= '0;
                r_err     <= 1'b1;
                r_done    <= 1'b1;
            end else if (r_state == RUN) begin
                if (w_beat && (r_beatCnt != '1)) begin
                    r_beatCnt <= r_beatCnt + BEAT_W'(1);
                end
                if (w_lastBeat) begin
                    r_dataDone <= 1'b1;
                end
                if (w_stsFire) begin
                    r_stsDone <= 1'b1;
                end
                if (w_lenErr || w_stsErr || w_mismatch) begin
                    r_err <= 1'b1;
                end
                if (w_finish) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mm2s_read_check.sv
// Self-checking bench for mm2s_read_check: a table of directed transfers plus
// randomized transfers whose expected results come from a transfer-level model.
module tb_mm2s_read_check;

`ifdef MM2S_READ_CHECK_DATA_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    localparam logic [31:0] SEED = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [22:0] btt = '0;
    logic [3:0]  tag = '0;
    logic [71:0] cmd_tdata;
    logic        cmd_tvalid;
    logic        cmd_tready = 1'b0;
    logic [31:0] s_tdata = '0;
    logic [3:0]  s_tkeep = 4'hF;
    logic        s_tlast = 1'b0;
    logic        s_tvalid = 1'b0;
    logic        s_tready;
    logic [7:0]  sts_tdata = '0;
    logic        sts_tvalid = 1'b0;
    logic        sts_tready;
    logic        busy;
    logic        done;
    logic        err;
    logic [20:0] beat_cnt;
    logic [20:0] err_beats;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] base;
        logic [22:0] btt;
        logic [3:0]  tag;
        logic [7:0]  sts;
        int          nBeats;
        int          corrupt;
        int          cmdDelay;
        int          validPct;
        int          stsWhen;
        bit          pulseStart;
        int          abortAt;
        logic [71:0] expCmd;
        int          expBeats;
        bit          expErr;
        int          expErrBeats;
    } xfer_t;

    xfer_t vecs[9];

    mm2s_read_check dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .btt        (btt),
        .tag        (tag),
        .cmd_tdata  (cmd_tdata),
        .cmd_tvalid (cmd_tvalid),
        .cmd_tready (cmd_tready),
        .s_tdata    (s_tdata),
        .s_tkeep    (s_tkeep),
        .s_tlast    (s_tlast),
        .s_tvalid   (s_tvalid),
        .s_tready   (s_tready),
        .sts_tdata  (sts_tdata),
        .sts_tvalid (sts_tvalid),
        .sts_tready (sts_tready),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .beat_cnt   (beat_cnt),
        .err_beats  (err_beats)
    );

    always #5 clk = ~clk;

    // Watchdog so the run always ends even if something wedges
    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: actual timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Transfer-level reference: command fields, ceil(btt/4) length rule, status and data errors
    function automatic xfer_t model(input xfer_t v);
        xfer_t m;
        int    eb;
        bit    stsBad;
        bit    dataBad;
        m       = v;
        eb      = (int'(v.btt) + 3) / 4;
        stsBad  = (v.sts[7] == 1'b0) || (v.sts[6:4] != 3'b000) || (v.sts[3:0] != v.tag);
        dataBad = CHK && (v.corrupt >= 0) && (v.corrupt < v.nBeats);
        m.expCmd      = {4'h0, v.tag, v.base, 1'b0, 1'b1, 6'h00, 1'b1, v.btt};
        m.expBeats    = v.nBeats;
        m.expErr      = (v.nBeats != eb) || stsBad || dataBad;
        m.expErrBeats = dataBad ? 1 : 0;
        return m;
    endfunction

    task automatic applyStimulus(input xfer_t v);
        int sent;
        int lastEvt;
        int doneCyc;
        int budget;
        int extraDones;
        bit stsSent;
        bit quiet;
        bit stable;
        bit aborted;
        bit tailChecked;

        @(negedge clk);
        start     = 1'b1;
        base_addr = v.base;
        btt       = v.btt;
        tag       = v.tag;
        @(negedge clk);
        start     = 1'b0;
        base_addr = ~v.base;
        btt       = 23'h1;
        tag       = ~v.tag;
        checkOutput("cmdValid", 72'(cmd_tvalid), 72'(1));
        checkOutput("cmdData", cmd_tdata, v.expCmd);
        checkOutput("busyCmd", 72'(busy), 72'(1));

        stable = 1'b1;
        for (int i = 0; i < v.cmdDelay; i++) begin
            @(negedge clk);
            if (cmd_tvalid !== 1'b1 || cmd_tdata !== v.expCmd) stable = 1'b0;
        end
        if (v.cmdDelay > 0) checkOutput("cmdStable", 72'(stable), 72'(1));
        cmd_tready = 1'b1;
        @(negedge clk);
        cmd_tready = 1'b0;
        checkOutput("cmdDrop", 72'(cmd_tvalid), 72'(0));

        sent        = 0;
        stsSent     = 1'b0;
        lastEvt     = -1;
        doneCyc     = -1;
        quiet       = 1'b1;
        aborted     = 1'b0;
        tailChecked = 1'b0;
        budget      = v.nBeats * 10 + 200;
        for (int c = 0; c < budget; c++) begin
            if (v.abortAt > 0 && sent == v.abortAt) begin
                aborted = 1'b1;
                break;
            end
            if (done) begin
                doneCyc = c;
                break;
            end
            if (c == 0) checkOutput("busyRun", 72'(busy), 72'(1));
            if (cmd_tvalid) quiet = 1'b0;
            start    = v.pulseStart && (c == 2);
            s_tvalid = (sent < v.nBeats) && ($urandom_range(0, 99) < v.validPct);
            s_tdata  = (sent == v.corrupt) ? 32'h0 : SEED - 32'(sent);
            s_tlast  = (sent == v.nBeats - 1);
            case (v.stsWhen)
                0:       sts_tvalid = !stsSent;
                1:       sts_tvalid = !stsSent && s_tvalid && s_tlast;
                default: sts_tvalid = !stsSent && (sent == v.nBeats);
            endcase
            sts_tdata = v.sts;
            if (sent == v.nBeats && !stsSent && !tailChecked) begin
                checkOutput("treadyAfterLast", 72'(s_tready), 72'(0));
                tailChecked = 1'b1;
            end
            if (s_tvalid && s_tready) begin
                sent++;
                if (s_tlast) lastEvt = c;
            end
            if (sts_tvalid && sts_tready) begin
                stsSent = 1'b1;
                lastEvt = c;
            end
            @(negedge clk);
        end
        start      = 1'b0;
        s_tvalid   = 1'b0;
        s_tlast    = 1'b0;
        sts_tvalid = 1'b0;

        if (aborted) begin
            reset = 1'b1;
            @(negedge clk);
            checkOutput("rstCmdValid", 72'(cmd_tvalid), 72'(0));
            checkOutput("rstReadies", 72'({s_tready, sts_tready}), 72'(0));
            checkOutput("rstBusyDoneErr", 72'({busy, done, err}), 72'(0));
            checkOutput("rstCounts", 72'({beat_cnt, err_beats}), 72'(0));
            reset = 1'b0;
            return;
        end
        if (doneCyc < 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL doneTimeout: actual no done required done within %0d cycles", budget);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
            return;
        end
        checkOutput("doneLatency", 72'(doneCyc), 72'(lastEvt + 1));
        checkOutput("beatCnt", 72'(beat_cnt), 72'(v.expBeats));
        checkOutput("err", 72'(err), 72'(v.expErr));
        checkOutput("errBeats", 72'(err_beats), 72'(v.expErrBeats));
        checkOutput("busyDone", 72'(busy), 72'(0));

        extraDones = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) extraDones++;
            if (cmd_tvalid) quiet = 1'b0;
        end
        checkOutput("singleDone", 72'(extraDones), 72'(0));
        checkOutput("noExtraCmd", 72'(quiet), 72'(1));
        checkOutput("beatCntHold", 72'(beat_cnt), 72'(v.expBeats));
    endtask

    initial begin
        vecs[0] = '{32'h0, 23'h4000, 4'hA, 8'h8A, 4096, -1, 0, 100, 2, 1'b0, 0,
                    72'h0A_0000_0000_4080_4000, 4096, 1'b0, 0};
        vecs[1] = '{32'h0, 23'h4000, 4'hA, 8'h8A, 4096, -1, 20, 50, 0, 1'b0, 0,
                    72'h0A_0000_0000_4080_4000, 4096, 1'b0, 0};
        vecs[2] = '{32'h0, 23'h4000, 4'hA, 8'h8A, 4096, 99, 0, 100, 1, 1'b0, 0,
                    72'h0A_0000_0000_4080_4000, 4096, CHK, int'(CHK)};
        vecs[3] = '{32'h0, 23'h4000, 4'hA, 8'h8A, 4095, -1, 0, 100, 2, 1'b0, 0,
                    72'h0A_0000_0000_4080_4000, 4095, 1'b1, 0};
        vecs[4] = '{32'h0, 23'h4000, 4'hA, 8'h4A, 4096, -1, 0, 100, 0, 1'b0, 0,
                    72'h0A_0000_0000_4080_4000, 4096, 1'b1, 0};
        vecs[5] = '{32'h0, 23'h4000, 4'hA, 8'h85, 4096, -1, 0, 100, 2, 1'b0, 0,
                    72'h0A_0000_0000_4080_4000, 4096, 1'b1, 0};
        vecs[6] = '{32'h200, 23'h10, 4'h7, 8'h87, 4, -1, 2, 100, 2, 1'b1, 0,
                    72'h07_0000_0200_4080_0010, 4, 1'b0, 0};
        vecs[7] = '{32'h1000_0000, 23'h4000, 4'h3, 8'h83, 4096, -1, 0, 100, 2, 1'b0, 500,
                    72'h03_1000_0000_4080_4000, 4096, 1'b0, 0};
        vecs[8] = '{32'h1000_0000, 23'h4000, 4'h3, 8'h83, 4096, -1, 1, 70, 1, 1'b0, 0,
                    72'h03_1000_0000_4080_4000, 4096, 1'b0, 0};

        $display("[TB] reset phase");
        repeat (3) @(negedge clk);
        reset = 1'b0;
        checkOutput("resetCmdValid", 72'(cmd_tvalid), 72'(0));
        checkOutput("resetReadies", 72'({s_tready, sts_tready}), 72'(0));
        checkOutput("resetBusyDoneErr", 72'({busy, done, err}), 72'(0));
        checkOutput("resetCounts", 72'({beat_cnt, err_beats}), 72'(0));

        $display("[TB] directed transfer table");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i]);
        end

        $display("[TB] zero-length start");
        @(negedge clk);
        start = 1'b1;
        btt   = 23'h0;
        tag   = 4'h2;
        @(negedge clk);
        start = 1'b0;
        checkOutput("zeroCmdValid", 72'(cmd_tvalid), 72'(0));
        checkOutput("zeroDone", 72'(done), 72'(1));
        checkOutput("zeroErr", 72'(err), 72'(1));
        checkOutput("zeroBusy", 72'(busy), 72'(0));
        @(negedge clk);
        checkOutput("zeroDonePulse", 72'(done), 72'(0));
        checkOutput("zeroNoCmd", 72'(cmd_tvalid), 72'(0));

        $display("[TB] randomized transfers");
        for (int r = 0; r < 12; r++) begin
            xfer_t v;
            int    eb;
            int    pick;
            v.base   = $urandom;
            v.btt    = 23'($urandom_range(1, 256));
            v.tag    = 4'($urandom);
            eb       = (int'(v.btt) + 3) / 4;
            pick     = int'($urandom_range(0, 3));
            v.nBeats = (pick == 0) ? eb - 1 : (pick == 3) ? eb + 1 : eb;
            if (v.nBeats < 1) v.nBeats = 1;
            v.sts        = ($urandom_range(0, 3) != 0) ? {4'h8, v.tag} : 8'($urandom);
            v.corrupt    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, v.nBeats - 1)) : -1;
            v.cmdDelay   = int'($urandom_range(0, 3));
            v.validPct   = int'($urandom_range(30, 100));
            v.stsWhen    = int'($urandom_range(0, 2));
            v.pulseStart = 1'($urandom_range(0, 1));
            v.abortAt    = 0;
            applyStimulus(model(v));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
